eeg_mean_mc: RTL and testbench
==============================

EEG_MEAN_MC -- requirements
Module: eeg_mean_mc

Interface
REQ-001 Parameters SHALL be: N_CH, 4, number of EEG channels.
REQ-002 DATA_W, 18, signed sample width, two's complement, Q1.5.12 at default.
REQ-003 MAX_WIN_LOG2, 8, log2 of the maximum window length (256 samples).
REQ-004 Derived: ACC_W = DATA_W+MAX_WIN_LOG2; CH_W = max(1,$clog2(N_CH)); WL_W = MAX_WIN_LOG2+1.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
 clk  in  1  single clock, rising edge;
 reset  in  1  asynchronous, active-high reset;
 start  in  1  pulse: latch win_len/continuous, clear accumulators, arm;
 win_len  in  WL_W  samples per channel per window;
 continuous  in  1  1 = re-arm after each window, 0 = one window then idle;
 in_valid  in  1  sample strobe;
 in_ready  out  1  block accepts samples;
 in_ch  in  CH_W  channel of the sample;
 in_data  in  DATA_W  signed sample;
 out_valid  out  1  mean result valid;
 out_ready  in  1  consumer accepts result;
 out_ch  out  CH_W  channel of the result;
 out_mean  out  DATA_W  signed mean, same format as in_data;
 busy  out  1  state is not IDLE;
 drop_err  out  1  sticky: a sample was dropped.

Function
REQ-006 The FSM SHALL have states IDLE, ACCUM, DIVIDE, OUTPUT.
REQ-007 IDLE: start -> ACCUM; start in any other state SHALL abort and restart in ACCUM, discarding partial sums and any pending result.
REQ-008 On start, win_len SHALL be latched as WL, clamped to [1, 2^MAX_WIN_LOG2] (0 -> 1); continuous SHALL be latched.
REQ-009 in_ready SHALL be 1 only in ACCUM; a sample transfers when in_valid && in_ready.
REQ-010 A transfer SHALL add sign-extended in_data to acc[in_ch] and increment cnt[in_ch] in the same cycle.
REQ-011 A transfer to a channel with cnt == WL, or with in_ch >= N_CH, SHALL be dropped and set drop_err; drop_err clears only on reset or start.
REQ-012 When every channel's cnt equals WL (evaluated after the current transfer), the next state SHALL be DIVIDE, channel index 0.
REQ-013 DIVIDE SHALL compute acc[ch]/WL by sign-magnitude restoring division, one quotient bit per cycle, ACC_W cycles per channel, truncating toward zero.
REQ-014 The quotient SHALL fit DATA_W bits by construction; out_mean is its low DATA_W bits with the sign re-applied.
REQ-015 After each division the state SHALL be OUTPUT with out_valid=1, out_ch=ch, out_mean held stable until out_valid && out_ready.
REQ-016 On handshake: if ch < N_CH-1 -> DIVIDE for ch+1; else clear all acc/cnt and go to ACCUM if continuous, IDLE otherwise.
REQ-017 Window latency: last accepted sample to first out_valid = ACC_W+2 cycles (1 FSM transition, ACC_W iterations, 1 register); consecutive channels add ACC_W+1 cycles plus backpressure.
REQ-018 Samples presented outside ACCUM SHALL be ignored without setting drop_err.

Reset
REQ-019 reset SHALL asynchronously force: state IDLE, all acc/cnt 0, WL 1, continuous 0, in_ready 0, out_valid 0, out_ch 0, out_mean 0, busy 0, drop_err 0.
REQ-020 Deassertion SHALL be synchronous to clk; the first post-reset edge SHALL honour start.

Structure
REQ-021 Package eeg_mean_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-022 Division SHALL be the sub-module eeg_seq_div (start/done handshake, parameterised dividend/divisor widths); no DesignWare dependency.
REQ-023 Accumulators and counters SHALL be register arrays indexed by channel; there SHALL be no multiplier.

Verification
REQ-024 N_CH=4, WL=4, round-robin samples, ch c = {1.0,2.0,3.0,4.0}+c -> out_mean = 2.5+c (0x02800+c*0x01000) in order ch0..ch3.
REQ-025 WL=3, ch0 samples {-1,-1,-2} LSB -> out_mean = -1 (truncation toward zero from -4/3); positive mirror {1,1,2} -> 1.
REQ-026 WL=256, all samples 0x1FFFF (max positive) -> out_mean 0x1FFFF, no overflow; all 0x20000 -> 0x20000.
REQ-027 out_ready held 0 for 10 cycles on ch1 -> out_valid, out_ch=1, out_mean stable; in_ready stays 0 throughout.
REQ-028 Fifth sample to ch2 with WL=4, and a sample with in_ch=5 (N_CH=4) -> drop_err=1, sums unchanged; start clears drop_err.
REQ-029 reset asserted mid-DIVIDE and start asserted mid-ACCUM -> all outputs reach reset values / accumulators clear; next window's means are correct.

Source files
------------

// File: rtl/eeg_mean_pkg.sv
// eeg_mean_pkg: shared state encoding and default sizing for the per-channel EEG mean block
package eeg_mean_pkg;
  localparam int N_CH_D = 4;
  localparam int DATA_W_D = 18;
  localparam int MAX_WIN_LOG2_D = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_t;
endpackage

// File: rtl/eeg_mean_mc_if.sv
// eeg_mean_mc_if: control, sample-in and mean-out signals of eeg_mean_mc
// master drives start/win_len/continuous, the sample stream and out_ready;
// slave returns in_ready, the mean result stream, busy and drop_err.
interface eeg_mean_mc_if import eeg_mean_pkg::*; #(
  parameter int N_CH = N_CH_D,
  parameter int DATA_W = DATA_W_D,
  parameter int MAX_WIN_LOG2 = MAX_WIN_LOG2_D
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WL_W = MAX_WIN_LOG2 + 1;
  logic start;
  logic [WL_W-1:0] win_len;
  logic continuous;
  logic in_valid;
  logic in_ready;
  logic [CH_W-1:0] in_ch;
  logic signed [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [CH_W-1:0] out_ch;
  logic signed [DATA_W-1:0] out_mean;
  logic busy;
  logic drop_err;
  modport master (
    output start, win_len, continuous, in_valid, in_ch, in_data, out_ready,
    input in_ready, out_valid, out_ch, out_mean, busy, drop_err
  );
  modport slave (
    input start, win_len, continuous, in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_mean, busy, drop_err
  );
endinterface

// File: rtl/eeg_seq_div.sv
// eeg_seq_div: sign-magnitude restoring divider, one quotient bit per cycle, truncates toward zero
// ports: clk, reset (async high), abort (cancel in-flight division), start (load num/den),
//        num (signed dividend), den (unsigned divisor, nonzero), done (1-cycle pulse), quo (signed quotient)
module eeg_seq_div #(
  parameter int NUM_W = 26,
  parameter int DEN_W = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    abort,
  input  logic                    start,
  input  logic signed [NUM_W-1:0] num,
  input  logic        [DEN_W-1:0] den,
  output logic                    done,
  output logic signed [NUM_W-1:0] quo
);
  localparam int N_W = $clog2(NUM_W + 1);
  logic [NUM_W-1:0] mag;
  logic [DEN_W-1:0] rem, d;
  logic [N_W-1:0] n;
  logic neg, run, ge;
  logic [DEN_W:0] trial, diff;
  // mag shifts dividend bits out of the top and quotient bits in at the bottom
  always_comb begin
    trial = {rem, mag[NUM_W-1]};
    diff = trial - {1'b0, d};
    ge = trial >= {1'b0, d};
  end
  assign quo = neg ? -$signed(mag) : $signed(mag);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mag <= '0;
      rem <= '0;
      d <= '0;
      n <= '0;
      neg <= 1'b0;
      run <= 1'b0;
      done <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      mag <= $unsigned(num[NUM_W-1] ? -num : num);
      neg <= num[NUM_W-1];
      rem <= '0;
      d <= den;
      n <= N_W'(NUM_W);
      run <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      mag <= {mag[NUM_W-2:0], ge};
      rem <= ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
      n <= n - N_W'(1);
      run <= n != N_W'(1);
      done <= n == N_W'(1);
    end else
      done <= 1'b0;
endmodule

// File: rtl/eeg_mean_mc.sv
// eeg_mean_mc: windowed per-channel mean of a multiplexed EEG sample stream
// ports: clk, reset (async high), bus (eeg_mean_mc_if.slave: start/win_len/continuous control,
//        in_valid/in_ready/in_ch/in_data samples, out_valid/out_ready/out_ch/out_mean results,
//        busy and sticky drop_err status)
module eeg_mean_mc import eeg_mean_pkg::*; #(
  parameter int N_CH = N_CH_D,
  parameter int DATA_W = DATA_W_D,
  parameter int MAX_WIN_LOG2 = MAX_WIN_LOG2_D
) (
  input logic         clk,
  input logic         reset,
  eeg_mean_mc_if.slave bus
);
  localparam int ACC_W = DATA_W + MAX_WIN_LOG2;
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WL_W = MAX_WIN_LOG2 + 1;
  localparam logic [WL_W-1:0] WL_MAX = WL_W'(1 << MAX_WIN_LOG2);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  state_t state, nxt;
  logic signed [ACC_W-1:0] acc [N_CH];
  logic [WL_W-1:0] cnt [N_CH];
  logic [WL_W-1:0] wl, wl_in;
  logic [CH_W-1:0] ch, div_ch;
  logic signed [DATA_W-1:0] mean;
  logic signed [ACC_W-1:0] div_quo;
  logic cont, launched, drop, hit, full, last, hs, div_go, div_done;
  // full looks at the counts as they will be after this cycle's transfer.
  // The next channel's division is launched on the handshake edge itself,
  // the first one on entry to DIVIDE (launched marks one in flight).
  always_comb begin
    wl_in = bus.win_len == '0 ? WL_W'(1) : bus.win_len > WL_MAX ? WL_MAX : bus.win_len;
    hit = state == ACCUM && bus.in_valid && 32'(bus.in_ch) < N_CH && cnt[bus.in_ch] != wl;
    full = 1'b1;
    for (int c = 0; c < N_CH; c++)
      full = full && (((hit && bus.in_ch == CH_W'(c)) ? cnt[c] + WL_W'(1) : cnt[c]) == wl);
    last = ch == CH_LAST;
    hs = state == OUTPUT && bus.out_ready;
    div_go = (state == DIVIDE && !launched) || (hs && !last);
    div_ch = hs ? ch + CH_W'(1) : ch;
    nxt = bus.start ? ACCUM :
          state == IDLE ? IDLE :
          state == ACCUM ? (full ? DIVIDE : ACCUM) :
          state == DIVIDE ? (div_done ? OUTPUT : DIVIDE) :
          !hs ? OUTPUT : !last ? DIVIDE : cont ? ACCUM : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wl <= WL_W'(1);
      cont <= 1'b0;
      ch <= '0;
      launched <= 1'b0;
      drop <= 1'b0;
      mean <= '0;
      for (int c = 0; c < N_CH; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      state <= nxt;
      if (bus.start) begin
        wl <= wl_in;
        cont <= bus.continuous;
        ch <= '0;
        launched <= 1'b0;
        drop <= 1'b0;
        for (int c = 0; c < N_CH; c++) begin
          acc[c] <= '0;
          cnt[c] <= '0;
        end
      end else begin
        if (hit) begin
          acc[bus.in_ch] <= acc[bus.in_ch] + {{MAX_WIN_LOG2{bus.in_data[DATA_W-1]}}, bus.in_data};
          cnt[bus.in_ch] <= cnt[bus.in_ch] + WL_W'(1);
        end
        if (state == ACCUM && bus.in_valid && !hit)
          drop <= 1'b1;
        if (state == ACCUM && full)
          ch <= '0;
        if (div_go)
          launched <= 1'b1;
        if (div_done) begin
          launched <= 1'b0;
          mean <= div_quo[DATA_W-1:0];
        end
        if (hs && !last)
          ch <= ch + CH_W'(1);
        if (hs && last)
          for (int c = 0; c < N_CH; c++) begin
            acc[c] <= '0;
            cnt[c] <= '0;
          end
      end
    end
  eeg_seq_div #(.NUM_W(ACC_W), .DEN_W(WL_W)) u_div (
    .clk(clk),
    .reset(reset),
    .abort(bus.start),
    .start(div_go),
    .num(acc[div_ch]),
    .den(wl),
    .done(div_done),
    .quo(div_quo)
  );
  assign bus.in_ready = state == ACCUM;
  assign bus.out_valid = state == OUTPUT;
  assign bus.out_ch = ch;
  assign bus.out_mean = mean;
  assign bus.busy = state != IDLE;
  assign bus.drop_err = drop;
endmodule

// File: tb/tb_eeg_mean_mc.sv
// tb_eeg_mean_mc: directed self-checking bench for eeg_mean_mc against a window-mean model
module tb_eeg_mean_mc;
  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int ACC_W = 26;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  eeg_mean_mc_if bus();
  eeg_mean_mc dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {int ch; int mean;} res_t;
  res_t exp_q[$];
  res_t got_q[$];
  int tests = 0;
  int fails = 0;
  int m_sum [N_CH];
  int m_cnt [N_CH];
  int m_wl = 1;
  bit m_cont = 1'b0;
  bit m_accum = 1'b0;
  bit m_drop = 1'b0;
  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_sum[c] = 0;
      m_cnt[c] = 0;
    end
    exp_q.delete();
  endtask
  task automatic model_sample(int c, int d);
    int k;
    bit all;
    k = c % (1 << CH_W);
    all = 1'b1;
    if (!m_accum) return;
    if (k >= N_CH || m_cnt[k] == m_wl) begin
      m_drop = 1'b1;
      return;
    end
    m_sum[k] += d;
    m_cnt[k]++;
    for (int i = 0; i < N_CH; i++) all &= (m_cnt[i] == m_wl);
    if (all) begin
      for (int i = 0; i < N_CH; i++) exp_q.push_back('{i, m_sum[i] / m_wl});
      for (int i = 0; i < N_CH; i++) begin
        m_sum[i] = 0;
        m_cnt[i] = 0;
      end
      m_accum = 1'b0;
    end
  endtask
  task automatic send(int c, int d);
    bus.in_valid = 1'b1;
    bus.in_ch = CH_W'(c);
    bus.in_data = 18'(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_sample(c, d);
  endtask
  task automatic do_start(int w, bit cn);
    bus.win_len = 9'(w);
    bus.continuous = cn;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    model_clear();
    m_wl = (w == 0) ? 1 : (w > 256) ? 256 : w;
    m_cont = cn;
    m_accum = 1'b1;
    m_drop = 1'b0;
    got_q.delete();
  endtask
  task automatic wait_valid(string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid"}, int'(bus.out_valid), 1);
  endtask
  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask
  task automatic check_got(string name, int m0, int m1, int m2, int m3);
    int e [4];
    e = '{m0, m1, m2, m3};
    check({name, "_count"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) begin
        check({name, "_ch"}, got_q[i].ch, i);
        check({name, "_mean"}, got_q[i].mean, e[i]);
      end
  endtask
  always @(negedge clk)
    if (!reset) begin
      check("drop_err", int'(bus.drop_err), int'(m_drop));
      if (bus.out_valid) begin
        check("result_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("out_ch", int'(bus.out_ch), exp_q[0].ch);
          check("out_mean", int'(bus.out_mean), exp_q[0].mean);
          check("in_ready_while_valid", int'(bus.in_ready), 0);
          if (bus.out_ready) begin
            got_q.push_back('{int'(bus.out_ch), int'(bus.out_mean)});
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_accum = m_cont;
          end
        end
      end
    end
  initial begin
    int n;
    bus.start = 1'b0;
    bus.win_len = '0;
    bus.continuous = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ch = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_drop", int'(bus.drop_err), 0);
    check("rst_out_ch", int'(bus.out_ch), 0);
    check("rst_out_mean", int'(bus.out_mean), 0);
    reset = 1'b0;
    do_start(4, 1'b0);
    check("start_in_ready", int'(bus.in_ready), 1);
    check("start_busy", int'(bus.busy), 1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) send(c, (r + 1 + c) * 4096);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, ACC_W + 2);
    drain("rr");
    check_got("rr", 'h2800, 'h3800, 'h4800, 'h5800);
    check("rr_idle", int'(bus.busy), 0);
    do_start(3, 1'b0);
    send(0, -1); send(1, 1); send(2, 0); send(3, -3);
    send(0, -1); send(1, 1); send(2, 0); send(3, 0);
    send(0, -2); send(1, 2); send(2, 0); send(3, 0);
    send(0, 7);
    drain("trunc");
    check_got("trunc", -1, 1, 0, -1);
    check("ignored_no_drop", int'(bus.drop_err), 0);
    do_start(300, 1'b0);
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < 4; c++) send(c, (c < 2) ? 131071 : -131072);
    drain("full");
    check_got("full", 131071, 131071, -131072, -131072);
    bus.out_ready = 1'b0;
    do_start(0, 1'b1);
    for (int c = 0; c < 4; c++) send(c, 256 * (c + 1));
    wait_valid("bp0");
    check("bp0_ch", int'(bus.out_ch), 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    wait_valid("bp1");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_ch", int'(bus.out_ch), 1);
      check("bp_mean", int'(bus.out_mean), 512);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    drain("bp");
    check_got("bp", 256, 512, 768, 1024);
    check("cont_rearm", int'(bus.in_ready), 1);
    got_q.delete();
    for (int c = 0; c < 4; c++) send(c, -3 * (c + 1));
    drain("cont2");
    check_got("cont2", -3, -6, -9, -12);
    do_start(4, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        send(c, 16 * (c + 1));
        if (r == 3 && c == 2) begin
          send(2, 999);
          check("drop_set", int'(bus.drop_err), 1);
          send(5, 1234);
        end
      end
    drain("drop");
    check_got("drop", 16, 32, 48, 64);
    do_start(2, 1'b0);
    check("drop_clr", int'(bus.drop_err), 0);
    send(0, 100);
    send(1, 200);
    do_start(2, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) send(c, (c + 1) * 8 + 2 * r);
    drain("restart");
    check_got("restart", 9, 17, 25, 33);
    do_start(1, 1'b0);
    for (int c = 0; c < 4; c++) send(c, 50);
    repeat (10) @(posedge clk);
    #1;
    check("mid_div_busy", int'(bus.busy), 1);
    reset = 1'b1;
    model_clear();
    m_accum = 1'b0;
    m_drop = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_in_ready", int'(bus.in_ready), 0);
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_out_ch", int'(bus.out_ch), 0);
    check("arst_out_mean", int'(bus.out_mean), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_start(1, 1'b0);
    send(0, -7); send(1, -8); send(2, 7); send(3, 8);
    drain("post_rst");
    check_got("post_rst", -7, -8, 7, 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
